multiboot_request_ctrl: RTL and testbench
=========================================

Name: multiboot_request_ctrl

Overview:
Register front end that sits directly upstream of the ICAP multiboot sequencer. It collects the 24-bit SPI flash core address through the ZXUNO register port and arms a reboot when the COREBOOT register is written. After a hold-off period it hands a stable address plus a level request to the sequencer, and holds the request until the sequencer acknowledges. Because the request is a level held until acknowledge, the sequencer's divided ICAP clock cannot miss it.

Parameters:
ADDR_COREADDR, 8'hFC, ZXUNO register number for the core address (3-byte shift register).
ADDR_COREBOOT, 8'hFD, ZXUNO register number for boot command / status.
GOLDEN_CORE, 24'h058000, fallback flash address; reset value of the address register.
HOLDOFF_CYCLES, 16'd1024, clk cycles between boot command and request assertion (lets SPI/SD traffic drain).
ACK_TIMEOUT, 16'd4096, clk cycles to wait for reboot_ack before flagging an error.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
zxuno_addr  in  8  currently selected ZXUNO register
regaddr_changed  in  1  one-cycle pulse: zxuno_addr was just rewritten
zxuno_regrd  in  1  register read strobe (level, multi-cycle)
zxuno_regwr  in  1  register write strobe (level, multi-cycle)
din  in  8  write data
dout  out  8  read data
oe  out  1  dout valid; asserted when reading one of this block's registers
boot_addr  out  24  flash address for the sequencer; stable while reboot_req=1
reboot_req  out  1  level reboot request to the sequencer
reboot_ack  in  1  sequencer has taken the request (level or pulse)
busy  out  1  high in HOLDOFF or REQ

Behaviour:
- Reset values:
  - spi_addr=GOLDEN_CORE, boot_addr=GOLDEN_CORE.
  - wr_cnt=0, rd_chunk=0, error=0, state=IDLE.
  - reboot_req=0, busy=0, dout=0.
- Strobe edge detection: a write or read acts once, on the first cycle the strobe is high with the matching address. It re-arms when the strobe goes low or the address no longer matches.
- Address write (ADDR_COREADDR):
  - spi_addr <= {spi_addr[15:0], din}.
  - wr_cnt increments and saturates at 3.
  - addr_valid = (wr_cnt==3).
- Address read (ADDR_COREADDR):
  - dout <= spi_addr[23:16], [15:8], [7:0] for rd_chunk 0, 1, 2; rd_chunk then wraps 2->0.
- regaddr_changed with zxuno_addr==ADDR_COREADDR: wr_cnt<=0, rd_chunk<=0. spi_addr is kept.
- Status read (ADDR_COREBOOT): dout <= {5'b0, error, busy, addr_valid}.
- oe is combinational: (zxuno_addr is ADDR_COREADDR or ADDR_COREBOOT) && zxuno_regrd.
- FSM states:
  - IDLE:
    - COREBOOT write with din[0]=1: boot_addr <= addr_valid ? spi_addr : GOLDEN_CORE; error<=0; counter<=0; go to HOLDOFF.
    - din[0]=0: no action.
  - HOLDOFF:
    - counter increments each cycle; at HOLDOFF_CYCLES-1, go to REQ with counter<=0.
    - A COREBOOT write with din[0]=0 cancels and returns to IDLE. Cancel has priority over expiry in the same cycle.
  - REQ:
    - reboot_req=1.
    - reboot_ack=1 goes to DONE.
    - counter reaching ACK_TIMEOUT-1 without ack: error<=1, go to IDLE.
    - If ack arrives on the timeout cycle, ack wins.
  - DONE:
    - reboot_req stays 1, busy=0; terminal, since the FPGA reconfigures.
    - Only rst leaves DONE.
- busy = (state==HOLDOFF || state==REQ).
- boot_addr is frozen from leaving IDLE until re-entering IDLE. COREADDR writes while busy still update spi_addr but never boot_addr.
- A second boot command while busy or in DONE is ignored (except the cancel in HOLDOFF).
- rst at any time, including mid-HOLDOFF or mid-REQ: immediately deasserts reboot_req and busy, and restores all reset values.
- Counters are 16-bit unsigned. HOLDOFF_CYCLES=0 is treated as 1.

Test Plan:
- Reset, then read COREADDR three times, then a fourth time -> dout 8'h05, 8'h80, 8'h00, then 8'h05 again (chunk wrap); oe high only during reads.
- Write 8'h12, 8'h34, 8'h56 to COREADDR, then COREBOOT=8'h01 -> busy rises next cycle; reboot_req rises exactly HOLDOFF_CYCLES cycles later with boot_addr=24'h123456; status reads 8'h03.
- Write only 2 bytes after selecting COREADDR, then boot -> boot_addr=24'h058000 (GOLDEN_CORE fallback).
- Boot, then write COREBOOT=8'h00 at holdoff count 500 -> state IDLE, busy=0, reboot_req never asserts.
- Boot, hold reboot_ack=0 -> after HOLDOFF_CYCLES+ACK_TIMEOUT cycles reboot_req drops and status reads 8'h04 (error=1 with no new address bytes loaded since the last COREADDR select); a new boot clears error. Pulsing ack 10 cycles into REQ -> DONE, reboot_req held at 1.
- Assert rst for one cycle mid-REQ -> reboot_req=0, busy=0, COREADDR reads back 8'h05, 8'h80, 8'h00.

Source files
------------

// File: rtl/multiboot_request_ctrl_if.sv
// rtl/multiboot_request_ctrl_if.sv - ZXUNO register port and sequencer handshake bundle
interface multiboot_request_ctrl_if;
    logic [7:0]  zxuno_addr;
    logic        regaddr_changed;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic [23:0] boot_addr;
    logic        reboot_req;
    logic        reboot_ack;
    logic        busy;

    modport master (
        output zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, din, reboot_ack,
        input  dout, oe, boot_addr, reboot_req, busy
    );

    modport slave (
        input  zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, din, reboot_ack,
        output dout, oe, boot_addr, reboot_req, busy
    );
endinterface

// File: rtl/multiboot_request_ctrl.sv
// rtl/multiboot_request_ctrl.sv - multiboot address/command registers and level reboot request
module multiboot_request_ctrl #(
    parameter logic [7:0]  ADDR_COREADDR  = 8'hFC,
    parameter logic [7:0]  ADDR_COREBOOT  = 8'hFD,
    parameter logic [23:0] GOLDEN_CORE    = 24'h058000,
    parameter logic [15:0] HOLDOFF_CYCLES = 16'd1024,
    parameter logic [15:0] ACK_TIMEOUT    = 16'd4096
) (
    input  logic                     clk,
    input  logic                     rst,
    multiboot_request_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HOLDOFF, REQ, DONE} state_t;

    localparam logic [15:0] HOLD_LAST = (HOLDOFF_CYCLES == 16'd0) ? 16'd0 : HOLDOFF_CYCLES - 16'd1;
    localparam logic [15:0] ACK_LAST  = (ACK_TIMEOUT == 16'd0) ? 16'd0 : ACK_TIMEOUT - 16'd1;

    state_t      state, state_next;
    logic [15:0] counter;
    logic [23:0] spi_addr;
    logic [1:0]  wr_cnt;
    logic [1:0]  rd_chunk;
    logic        error;
    logic        busy_int;
    logic        addr_valid;

    logic sel_addr, sel_boot;
    logic addr_wr_lvl, addr_rd_lvl, boot_wr_lvl, boot_rd_lvl;
    logic addr_wr_d, addr_rd_d, boot_wr_d, boot_rd_d;
    logic addr_wr, addr_rd, boot_wr, boot_rd;
    logic boot_cmd, boot_cancel;

    assign sel_addr    = (bus.zxuno_addr == ADDR_COREADDR);
    assign sel_boot    = (bus.zxuno_addr == ADDR_COREBOOT);
    assign addr_wr_lvl = sel_addr && bus.zxuno_regwr;
    assign addr_rd_lvl = sel_addr && bus.zxuno_regrd;
    assign boot_wr_lvl = sel_boot && bus.zxuno_regwr;
    assign boot_rd_lvl = sel_boot && bus.zxuno_regrd;

    // Strobes are multi-cycle levels; act only on the first matching cycle.
    assign addr_wr = addr_wr_lvl && !addr_wr_d;
    assign addr_rd = addr_rd_lvl && !addr_rd_d;
    assign boot_wr = boot_wr_lvl && !boot_wr_d;
    assign boot_rd = boot_rd_lvl && !boot_rd_d;

    assign boot_cmd    = boot_wr && bus.din[0];
    assign boot_cancel = boot_wr && !bus.din[0];
    assign addr_valid  = (wr_cnt == 2'd3);
    assign busy_int    = (state == HOLDOFF) || (state == REQ);

    assign bus.oe         = (sel_addr || sel_boot) && bus.zxuno_regrd;
    assign bus.busy       = busy_int;
    assign bus.reboot_req = (state == REQ) || (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (boot_cmd) state_next = HOLDOFF;
            HOLDOFF: begin
                if (boot_cancel)               state_next = IDLE;
                else if (counter == HOLD_LAST) state_next = REQ;
            end
            REQ: begin
                if (bus.reboot_ack)           state_next = DONE;
                else if (counter == ACK_LAST) state_next = IDLE;
            end
            default: state_next = DONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            counter       <= 16'd0;
            bus.boot_addr <= GOLDEN_CORE;
            error         <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                counter <= 16'd0;
            else if (busy_int)
                counter <= counter + 16'd1;
            if (state == IDLE && boot_cmd) begin
                bus.boot_addr <= addr_valid ? spi_addr : GOLDEN_CORE;
                error         <= 1'b0;
            end else if (state == REQ && state_next == IDLE) begin
                error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_addr  <= GOLDEN_CORE;
            wr_cnt    <= 2'd0;
            rd_chunk  <= 2'd0;
            bus.dout  <= 8'h00;
            addr_wr_d <= 1'b0;
            addr_rd_d <= 1'b0;
            boot_wr_d <= 1'b0;
            boot_rd_d <= 1'b0;
        end else begin
            addr_wr_d <= addr_wr_lvl;
            addr_rd_d <= addr_rd_lvl;
            boot_wr_d <= boot_wr_lvl;
            boot_rd_d <= boot_rd_lvl;
            if (addr_wr) begin
                spi_addr <= {spi_addr[15:0], bus.din};
                if (wr_cnt != 2'd3) wr_cnt <= wr_cnt + 2'd1;
            end
            if (addr_rd) begin
                case (rd_chunk)
                    2'd0:    bus.dout <= spi_addr[23:16];
                    2'd1:    bus.dout <= spi_addr[15:8];
                    default: bus.dout <= spi_addr[7:0];
                endcase
                rd_chunk <= (rd_chunk >= 2'd2) ? 2'd0 : rd_chunk + 2'd1;
            end
            if (boot_rd)
                bus.dout <= {5'b0, error, busy_int, addr_valid};
            // Reselecting COREADDR restarts both byte sequences but keeps the address.
            if (bus.regaddr_changed && sel_addr) begin
                wr_cnt   <= 2'd0;
                rd_chunk <= 2'd0;
            end
        end
    end
endmodule

// File: tb/tb_multiboot_request_ctrl.sv
// tb/tb_multiboot_request_ctrl.sv - scoreboard bench for multiboot_request_ctrl
module tb_multiboot_request_ctrl;
    localparam int H = 1024;
    localparam int T = 4096;
    localparam logic [7:0] A_ADDR = 8'hFC;
    localparam logic [7:0] A_BOOT = 8'hFD;

    typedef struct {
        logic        level;
        int          cycle;
        logic [23:0] addr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiboot_request_ctrl_if bus();

    multiboot_request_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t        req_q[$];
    ev_t        busy_q[$];
    logic [7:0] rd_q[$];
    logic       exp_oe = 1'b0;
    logic       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic        req_prev = 1'b0;
    logic        busy_prev = 1'b0;
    int          oe_run = 0;
    logic [23:0] held_addr = 24'h0;
    ev_t         ev;

    always @(negedge clk) begin
        if (mon_en) begin
            check("oe", bus.oe, exp_oe);
            if (bus.oe) begin
                oe_run++;
                if (oe_run == 2) begin
                    if (rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dout_unexpected: got %0h expected none", bus.dout);
                    end else check("dout", bus.dout, rd_q.pop_front());
                end
            end else oe_run = 0;

            if (bus.reboot_req !== req_prev) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: got %0b expected none (cycle %0d)", bus.reboot_req, cyc);
                end else begin
                    ev = req_q.pop_front();
                    check("req_level", bus.reboot_req, ev.level);
                    check("req_cycle", cyc, ev.cycle);
                    if (ev.level) begin
                        check("boot_addr", bus.boot_addr, ev.addr);
                        held_addr = ev.addr;
                    end
                end
            end else if (bus.reboot_req) begin
                check("boot_addr_hold", bus.boot_addr, held_addr);
            end

            if (bus.busy !== busy_prev) begin
                if (busy_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL busy_unexpected: got %0b expected none (cycle %0d)", bus.busy, cyc);
                end else begin
                    ev = busy_q.pop_front();
                    check("busy_level", bus.busy, ev.level);
                    check("busy_cycle", cyc, ev.cycle);
                end
            end
            req_prev  = bus.reboot_req;
            busy_prev = bus.busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp);
        bus.zxuno_addr = addr;
        rd_q.push_back(exp);
        bus.zxuno_regrd = 1'b1;
        exp_oe = 1'b1;
        step(); step();
        bus.zxuno_regrd = 1'b0;
        exp_oe = 1'b0;
        step();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        bus.zxuno_addr = addr;
        bus.din = data;
        bus.zxuno_regwr = 1'b1;
        step(); step();
        bus.zxuno_regwr = 1'b0;
        step();
    endtask

    task automatic select_addr();
        bus.zxuno_addr = A_ADDR;
        bus.regaddr_changed = 1'b1;
        step();
        bus.regaddr_changed = 1'b0;
        step();
    endtask

    task automatic boot(input logic [23:0] exp_addr, input logic expect_req, output int t0);
        t0 = cyc;
        busy_q.push_back('{1'b1, t0 + 1, 24'h0});
        if (expect_req) req_q.push_back('{1'b1, t0 + 1 + H, exp_addr});
        wr(A_BOOT, 8'h01);
    endtask

    int t0, t1;

    initial begin
        bus.zxuno_addr = 8'h00;
        bus.regaddr_changed = 1'b0;
        bus.zxuno_regrd = 1'b0;
        bus.zxuno_regwr = 1'b0;
        bus.din = 8'h00;
        bus.reboot_ack = 1'b0;
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        step();

        check("rst_req", bus.reboot_req, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_boot_addr", bus.boot_addr, 24'h058000);
        check("rst_dout", bus.dout, 8'h00);
        check("rst_oe", bus.oe, 1'b0);
        mon_en = 1'b1;

        // Read-back of the golden address, chunk wrap on the fourth read
        rd(A_ADDR, 8'h05); rd(A_ADDR, 8'h80); rd(A_ADDR, 8'h00); rd(A_ADDR, 8'h05);

        // Full address, boot, status in HOLDOFF and REQ, then reset mid-REQ
        select_addr();
        wr(A_ADDR, 8'h12); wr(A_ADDR, 8'h34); wr(A_ADDR, 8'h56);
        boot(24'h123456, 1'b1, t0);
        step();
        rd(A_BOOT, 8'h03);
        wait_until(t0 + 1 + H + 20);
        rd(A_BOOT, 8'h03);
        rst = 1'b1;
        req_q.push_back('{1'b0, cyc, 24'h0});
        busy_q.push_back('{1'b0, cyc, 24'h0});
        step();
        rst = 1'b0;
        step();
        rd(A_ADDR, 8'h05); rd(A_ADDR, 8'h80); rd(A_ADDR, 8'h00);

        // Partial address falls back to golden; no ack leads to timeout
        select_addr();
        wr(A_ADDR, 8'h11); wr(A_ADDR, 8'h22);
        boot(24'h058000, 1'b1, t0);
        req_q.push_back('{1'b0, t0 + 1 + H + T, 24'h0});
        busy_q.push_back('{1'b0, t0 + 1 + H + T, 24'h0});
        wait_until(t0 + 1 + H + T + 5);
        rd(A_BOOT, 8'h04);

        // Cancel during HOLDOFF, request never asserts
        boot(24'h058000, 1'b0, t0);
        wait_until(t0 + 1 + 500);
        t1 = cyc;
        busy_q.push_back('{1'b0, t1 + 1, 24'h0});
        wr(A_BOOT, 8'h00);
        rd(A_BOOT, 8'h00);
        wait_until(t0 + 1 + H + 50);

        // Ack 10 cycles into REQ reaches DONE; later commands are ignored
        select_addr();
        wr(A_ADDR, 8'hAB); wr(A_ADDR, 8'hCD); wr(A_ADDR, 8'hEF);
        boot(24'hABCDEF, 1'b1, t0);
        wait_until(t0 + 1 + H + 10);
        busy_q.push_back('{1'b0, cyc + 1, 24'h0});
        bus.reboot_ack = 1'b1;
        step();
        bus.reboot_ack = 1'b0;
        step();
        wr(A_BOOT, 8'h01);
        wr(A_ADDR, 8'h99);
        repeat (H + 20) step();
        rd(A_BOOT, 8'h01);
        check("done_req", bus.reboot_req, 1'b1);
        check("done_busy", bus.busy, 1'b0);
        check("done_boot_addr", bus.boot_addr, 24'hABCDEF);

        step();
        check("req_q_empty", req_q.size(), 0);
        check("busy_q_empty", busy_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
